// File: rtl/isa_pkg.sv
// Shared ISA definitions for the decode stage: data/register types, opcodes and
// the one-hot flag bundle handed to execute.
package isa_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned NREG   = 16;

  typedef logic [DATA_W-1:0]       block;
  typedef logic [15:0]             addr;
  typedef logic [$clog2(NREG)-1:0] reg_idx;

  typedef enum logic [3:0] {
    OpHalt = 4'h0,
    OpAdd  = 4'h1,
    OpSub  = 4'h2,
    OpAnd  = 4'h3,
    OpOr   = 4'h4,
    OpGt   = 4'h5,
    OpEq   = 4'h6,
    OpLi   = 4'h7,
    OpSt   = 4'h8,
    OpLd   = 4'h9,
    OpBeq  = 4'hA,
    OpBgt  = 4'hB,
    OpRsvC = 4'hC,
    OpRsvD = 4'hD,
    OpRsvE = 4'hE,
    OpNop  = 4'hF
  } opcode_e;

  typedef struct packed {
    logic is_add;
    logic is_sub;
    logic is_and;
    logic is_or;
    logic is_gt;
    logic is_eq;
    logic is_mem_write;
    logic is_reg_write;
    logic is_halt;
    logic is_branch;
  } flags_t;

  localparam flags_t FlagsHalt = '{is_halt: 1'b1, default: 1'b0};

  // r1/r2 are register sources (hazard candidates) for these opcodes.
  function automatic logic uses_src(opcode_e op);
    return op inside {OpAdd, OpSub, OpAnd, OpOr, OpGt, OpEq, OpSt, OpLd, OpBeq, OpBgt};
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch/write-back/execute bundle around the decode stage. The master modport is the
// surrounding pipeline, the slave modport is decode_stage itself.
interface decode_stage_if;
  import isa_pkg::*;

  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        do_branch;
  logic        wb_en;
  reg_idx      wb_addr;
  block        wb_data;

  logic is_add, is_sub, is_and, is_or, is_gt, is_eq;
  logic is_mem_write, is_reg_write, is_halt, is_branch;
  block val1, val2, val3;
  logic is_val1_data_hazard, is_val2_data_hazard, is_mem_data_hazard;

  modport master (
    output instr, instr_valid, do_branch, wb_en, wb_addr, wb_data,
    input  instr_ready,
    input  is_add, is_sub, is_and, is_or, is_gt, is_eq,
    input  is_mem_write, is_reg_write, is_halt, is_branch,
    input  val1, val2, val3,
    input  is_val1_data_hazard, is_val2_data_hazard, is_mem_data_hazard
  );

  modport slave (
    input  instr, instr_valid, do_branch, wb_en, wb_addr, wb_data,
    output instr_ready,
    output is_add, is_sub, is_and, is_or, is_gt, is_eq,
    output is_mem_write, is_reg_write, is_halt, is_branch,
    output val1, val2, val3,
    output is_val1_data_hazard, is_val2_data_hazard, is_mem_data_hazard
  );

endinterface

// File: rtl/reg_file.sv
// Register file: three combinational read ports with write-through bypass, one write
// port, R0 hardwired to zero, all entries cleared on reset.
module reg_file
  import isa_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_we,
  input  reg_idx i_waddr,
  input  block   i_wdata,
  input  reg_idx i_ra [3],
  output block   o_rd [3]
);

  block r_mem [NREG];
  logic w_wr;

  assign w_wr = i_we && (i_waddr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (w_wr) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_rd
    always_comb begin
      if (i_ra[g] == '0) begin
        o_rd[g] = '0;
      end else if (w_wr && (i_waddr == i_ra[g])) begin
        o_rd[g] = i_wdata;
      end else begin
        o_rd[g] = r_mem[i_ra[g]];
      end
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decodes one instruction per cycle into the registered execute bundle,
// tracks RAW hazards and stalls register-indirect targets. DECODE_ILLEGAL_TRAP_EN makes
// opcodes C/D/E trap as halt instead of decoding as NOP.
module decode_stage
  import isa_pkg::*;
(
  input logic          clk,
  input logic          rst_n,
  decode_stage_if.slave dec_if
);

  opcode_e w_op;
  reg_idx  w_r1, w_r2, w_r3;
  reg_idx  w_ra [3];
  block    w_rd [3];

  assign w_op  = opcode_e'(dec_if.instr[15:12]);
  assign w_r3  = dec_if.instr[11:8];
  assign w_r1  = dec_if.instr[7:4];
  assign w_r2  = dec_if.instr[3:0];
  assign w_ra[0] = w_r1;
  assign w_ra[1] = w_r2;
  assign w_ra[2] = w_r3;

  reg_file u_reg_file (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (dec_if.wb_en),
    .i_waddr (dec_if.wb_addr),
    .i_wdata (dec_if.wb_data),
    .i_ra    (w_ra),
    .o_rd    (w_rd)
  );

  logic   r_prev_wr, r_prev_ld;
  reg_idx r_prev_rd;
  flags_t r_flags, w_flags;
  block   r_val1, r_val2, r_val3, w_val1, w_val2, w_val3;
  logic   r_haz1, r_haz2, r_haz_mem, w_haz1, w_haz2;
  logic   w_stall, w_issue, w_src;

  // Targets/store data come straight from the file, so a pending write must land first.
  assign w_stall = dec_if.instr_valid && !dec_if.do_branch &&
                   (w_op inside {OpSt, OpBeq, OpBgt}) && r_prev_wr && (w_r3 == r_prev_rd);
  assign w_issue = dec_if.instr_valid && !dec_if.do_branch && !w_stall;
  assign dec_if.instr_ready = !w_stall;

  assign w_src  = uses_src(w_op);
  assign w_haz1 = w_src && r_prev_wr && (w_r1 == r_prev_rd) && (r_prev_rd != '0);
  assign w_haz2 = w_src && r_prev_wr && (w_r2 == r_prev_rd) && (r_prev_rd != '0);

  always_comb begin
    w_flags = '0;
    w_val1  = w_rd[0];
    w_val2  = w_rd[1];
    w_val3  = block'(w_r3);
    case (w_op)
      OpHalt: w_flags.is_halt = 1'b1;
      OpAdd:  begin w_flags.is_add = 1'b1; w_flags.is_reg_write = 1'b1; end
      OpSub:  begin w_flags.is_sub = 1'b1; w_flags.is_reg_write = 1'b1; end
      OpAnd:  begin w_flags.is_and = 1'b1; w_flags.is_reg_write = 1'b1; end
      OpOr:   begin w_flags.is_or  = 1'b1; w_flags.is_reg_write = 1'b1; end
      OpGt:   begin w_flags.is_gt  = 1'b1; w_flags.is_reg_write = 1'b1; end
      OpEq:   begin w_flags.is_eq  = 1'b1; w_flags.is_reg_write = 1'b1; end
      OpLi: begin
        w_flags.is_add       = 1'b1;
        w_flags.is_reg_write = 1'b1;
        w_val1               = block'({w_r1, w_r2});
        w_val2               = '0;
      end
      OpSt: begin
        w_flags.is_add       = 1'b1;
        w_flags.is_mem_write = 1'b1;
        w_val3               = w_rd[2];
      end
      OpLd:   begin w_flags.is_add = 1'b1; w_flags.is_reg_write = 1'b1; end
      OpBeq:  begin w_flags.is_branch = 1'b1; w_flags.is_eq = 1'b1; w_val3 = w_rd[2]; end
      OpBgt:  begin w_flags.is_branch = 1'b1; w_flags.is_gt = 1'b1; w_val3 = w_rd[2]; end
`ifdef DECODE_ILLEGAL_TRAP_EN
      OpRsvC, OpRsvD, OpRsvE: w_flags.is_halt = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags   <= FlagsHalt;
      r_val1    <= '0;
      r_val2    <= '0;
      r_val3    <= '0;
      r_haz1    <= 1'b0;
      r_haz2    <= 1'b0;
      r_haz_mem <= 1'b0;
      r_prev_wr <= 1'b0;
      r_prev_rd <= '0;
      r_prev_ld <= 1'b0;
    end else if (w_issue) begin
      r_flags   <= w_flags;
      r_val1    <= w_val1;
      r_val2    <= w_val2;
      r_val3    <= w_val3;
      r_haz1    <= w_haz1;
      r_haz2    <= w_haz2;
      r_haz_mem <= r_prev_ld && (w_haz1 || w_haz2);
      r_prev_wr <= w_flags.is_reg_write;
      r_prev_rd <= w_r3;
      r_prev_ld <= (w_op == OpLd);
    end else begin
      r_flags   <= '0;
      r_val1    <= '0;
      r_val2    <= '0;
      r_val3    <= '0;
      r_haz1    <= 1'b0;
      r_haz2    <= 1'b0;
      r_haz_mem <= 1'b0;
      r_prev_wr <= 1'b0;
      r_prev_rd <= '0;
      r_prev_ld <= 1'b0;
    end
  end

  assign dec_if.is_add              = r_flags.is_add;
  assign dec_if.is_sub              = r_flags.is_sub;
  assign dec_if.is_and              = r_flags.is_and;
  assign dec_if.is_or               = r_flags.is_or;
  assign dec_if.is_gt               = r_flags.is_gt;
  assign dec_if.is_eq               = r_flags.is_eq;
  assign dec_if.is_mem_write        = r_flags.is_mem_write;
  assign dec_if.is_reg_write        = r_flags.is_reg_write;
  assign dec_if.is_halt             = r_flags.is_halt;
  assign dec_if.is_branch           = r_flags.is_branch;
  assign dec_if.val1                = r_val1;
  assign dec_if.val2                = r_val2;
  assign dec_if.val3                = r_val3;
  assign dec_if.is_val1_data_hazard = r_haz1;
  assign dec_if.is_val2_data_hazard = r_haz2;
  assign dec_if.is_mem_data_hazard  = r_haz_mem;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed cases followed by random traffic, all
// checked against an instruction-level reference model.
module tb_decode_stage;
  import isa_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decode_stage_if dif ();

  decode_stage u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .dec_if (dif)
  );

  // flags bit order: add sub and or gt eq mem_write reg_write halt branch
  typedef struct packed {
    logic [9:0]  flags;
    logic [15:0] v1;
    logic [15:0] v2;
    logic [15:0] v3;
    logic        c1;
    logic        c2;
    logic        c3;
    logic [2:0]  haz;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] mregs [16];
  logic        p_wr, p_ld;
  logic [3:0]  p_rd;
  logic        m_ready;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [9:0] dut_flags();
    return {dif.is_add, dif.is_sub, dif.is_and, dif.is_or, dif.is_gt, dif.is_eq,
            dif.is_mem_write, dif.is_reg_write, dif.is_halt, dif.is_branch};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mregs[i] = '0;
    p_wr = 1'b0;
    p_rd = '0;
    p_ld = 1'b0;
  endtask

  // One cycle of the architectural model: write-back first (bypass), then decode.
  task automatic model_step(input logic [15:0] ins, input logic v, input logic br,
                            input logic we, input logic [3:0] wa, input logic [15:0] wd,
                            output exp_t e, output logic rdy);
    int unsigned op, r1, r2, r3;
    logic stall, src, h1, h2;
    op = ins[15:12];
    r3 = ins[11:8];
    r1 = ins[7:4];
    r2 = ins[3:0];
    if (we && wa != 0) mregs[wa] = wd;
    stall = v && !br && (op == 8 || op == 10 || op == 11) && p_wr && (r3 == p_rd);
    rdy = !stall;
    e = '0;
    if (!v || br || stall) begin
      p_wr = 1'b0;
      p_rd = '0;
      p_ld = 1'b0;
    end else begin
      if (op >= 1 && op <= 6) begin
        e.flags[10-op] = 1'b1;
        e.flags[2]     = 1'b1;
        e.v1 = mregs[r1]; e.v2 = mregs[r2]; e.v3 = 16'(r3);
        e.c1 = 1'b1; e.c2 = 1'b1; e.c3 = 1'b1;
      end else if (op == 0) begin
        e.flags[1] = 1'b1;
      end else if (op == 7) begin
        e.flags[9] = 1'b1; e.flags[2] = 1'b1;
        e.v1 = 16'(r1 * 16 + r2); e.v2 = 16'h0; e.v3 = 16'(r3);
        e.c1 = 1'b1; e.c2 = 1'b1; e.c3 = 1'b1;
      end else if (op == 8) begin
        e.flags[9] = 1'b1; e.flags[3] = 1'b1;
        e.v1 = mregs[r1]; e.v2 = mregs[r2]; e.v3 = mregs[r3];
        e.c1 = 1'b1; e.c2 = 1'b1; e.c3 = 1'b1;
      end else if (op == 9) begin
        e.flags[9] = 1'b1; e.flags[2] = 1'b1;
        e.v3 = 16'(r3); e.c3 = 1'b1;
      end else if (op == 10 || op == 11) begin
        e.flags[0] = 1'b1;
        e.flags[op == 10 ? 4 : 5] = 1'b1;
        e.v3 = mregs[r3]; e.c3 = 1'b1;
      end else if (op >= 12 && op <= 14) begin
`ifdef DECODE_ILLEGAL_TRAP_EN
        e.flags[1] = 1'b1;
`endif
      end
      src = (op >= 1 && op <= 6) || (op >= 8 && op <= 11);
      h1  = src && p_wr && (r1 == p_rd) && (p_rd != 0);
      h2  = src && p_wr && (r2 == p_rd) && (p_rd != 0);
      e.haz = {h1, h2, p_ld && (h1 || h2)};
      p_wr = e.flags[2];
      p_rd = 4'(r3);
      p_ld = (op == 9);
    end
  endtask

  task automatic drive(input logic [15:0] ins, input logic v, input logic br,
                       input logic we, input logic [3:0] wa, input logic [15:0] wd);
    exp_t e;
    logic rdy;
    @(negedge clk);
    dif.instr       = ins;
    dif.instr_valid = v;
    dif.do_branch   = br;
    dif.wb_en       = we;
    dif.wb_addr     = wa;
    dif.wb_data     = wd;
    model_step(ins, v, br, we, wa, wd, e, rdy);
    #1;
    check("instr_ready", 32'(dif.instr_ready), 32'(rdy));
    q.push_back(e);
    m_ready = rdy;
  endtask

  task automatic idle_inputs();
    dif.instr       = 16'hF000;
    dif.instr_valid = 1'b0;
    dif.do_branch   = 1'b0;
    dif.wb_en       = 1'b0;
    dif.wb_addr     = '0;
    dif.wb_data     = '0;
  endtask

  task automatic reset_and_check();
    @(negedge clk);
    #2;
    idle_inputs();
    rst_n = 1'b0;
    model_clear();
    #1;
    check("rst_flags", 32'(dut_flags()), 32'(10'b0000000010));
    check("rst_vals", {dif.val1, dif.val2}, 32'h0);
    check("rst_val3", 32'(dif.val3), 32'h0);
    check("rst_haz", 32'({dif.is_val1_data_hazard, dif.is_val2_data_hazard,
                          dif.is_mem_data_hazard}), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready", 32'(dif.instr_ready), 32'h1);
    check("rst_halt_hold", 32'(dif.is_halt), 32'h1);
  endtask

  // Monitor: one registered bundle per edge, compared against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("flags", 32'(dut_flags()), 32'(e.flags));
        check("hazards", 32'({dif.is_val1_data_hazard, dif.is_val2_data_hazard,
                              dif.is_mem_data_hazard}), 32'(e.haz));
        if (e.c1) check("val1", 32'(dif.val1), 32'(e.v1));
        if (e.c2) check("val2", 32'(dif.val2), 32'(e.v2));
        if (e.c3) check("val3", 32'(dif.val3), 32'(e.v3));
      end
    end
  end

  initial begin
    logic [15:0] ins, held;
    logic        hold;
    idle_inputs();
    model_clear();
    m_ready = 1'b1;
    reset_and_check();

    drive(16'h7105, 1, 0, 0, 4'd0, 16'h0);    // LI r1,0x05
    drive(16'h1312, 1, 0, 0, 4'd0, 16'h0);    // ADD r3,r1,r2
    drive(16'h9400, 1, 0, 0, 4'd0, 16'h0);    // LD r4
    drive(16'h2544, 1, 0, 0, 4'd0, 16'h0);    // SUB r5,r4,r4
    drive(16'h4620, 1, 0, 1, 4'd2, 16'h1234); // OR r6,r2,r0 with write-back r2
    drive(16'h7733, 1, 0, 0, 4'd0, 16'h0);    // LI r7
    drive(16'hA712, 1, 0, 0, 4'd0, 16'h0);    // BEQ r7 -> stall
    drive(16'hA712, 1, 0, 1, 4'd7, 16'h0042); // held BEQ issues after write-back
    drive(16'h7711, 1, 0, 0, 4'd0, 16'h0);    // LI r7
    drive(16'hA712, 1, 1, 0, 4'd0, 16'h0);    // do_branch overrides the stall
    drive(16'hF000, 1, 0, 0, 4'd0, 16'h0);    // NOP
    drive(16'hC123, 1, 0, 0, 4'd0, 16'h0);    // reserved opcode
    drive(16'h7801, 1, 0, 0, 4'd0, 16'h0);    // LI r8
    drive(16'h8812, 1, 0, 0, 4'd0, 16'h0);    // ST r8 -> stall
    drive(16'h8812, 1, 0, 1, 4'd8, 16'h00AB); // held ST issues
    drive(16'h0000, 1, 0, 0, 4'd0, 16'h0);    // HALT
    drive(16'h1111, 0, 0, 0, 4'd0, 16'h0);    // no valid instruction
    @(posedge clk);
    #2;

    reset_and_check();
    drive(16'h4612, 1, 0, 0, 4'd0, 16'h0);    // registers cleared by reset

    hold = 1'b0;
    held = '0;
    for (int i = 0; i < 400; i++) begin
      if (hold) begin
        ins = held;
      end else begin
        ins = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
               4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      end
      drive(ins, hold ? 1'b1 : 1'($urandom_range(0, 9) != 0),
            1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 3)), 16'($urandom));
      hold = !m_ready;
      held = ins;
    end
    @(posedge clk);
    #2;
    check("queue_drained", 32'(q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Decode stage directly upstream of the execute stage. Accepts one 16-bit instruction per cycle from fetch, reads a 16-entry register file, and registers one-hot operation flags, operand values, a destination field and data-hazard flags into the exact input bundle execute consumes. Owns the register file and its write-back port. Handles branch flush and a one-cycle stall for register-indirect branch targets.

## Interface
- `DATA_W`, 16: operand width; `block` type width.
- `NREG`, 16: register count; index width 4.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `instr` in 16: instruction word; `[15:12]` op, `[11:8]` r3, `[7:4]` r1, `[3:0]` r2.
- `instr_valid` in 1: `instr` present this cycle.
- `instr_ready` out 1: combinational; low means hold `instr` (stall).
- `do_branch` in 1: from execute; flush.
- `wb_en` in 1, `wb_addr` in 4, `wb_data` in DATA_W: register-file write port.
- `is_add`, `is_sub`, `is_and`, `is_or`, `is_gt`, `is_eq`, `is_mem_write`, `is_reg_write`, `is_halt`, `is_branch` out 1 each: registered flags.
- `val1`, `val2`, `val3` out DATA_W: registered operands.
- `is_val1_data_hazard`, `is_val2_data_hazard`, `is_mem_data_hazard` out 1: registered forwarding selects.

## Operation
- Opcodes:
  - 0 HALT.
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 GT, 6 EQ: reg write; `val1`=R[r1], `val2`=R[r2], `val3`=r3 zero-extended.
  - 7 LI: `is_add` + reg write; `val1`={r1,r2} zero-extended, `val2`=0.
  - 8 ST: `is_mem_write`, `is_add`; `val1`=R[r1], `val2`=R[r2] (address = sum); `val3`=R[r3] (store data).
  - 9 LD: `is_add`, reg write; `val3`=r3.
  - A BEQ, B BGT: `is_branch` + `is_eq`/`is_gt`; `val3`=R[r3] (target).
  - F NOP: all flags 0.
  - Others: see Configuration.
- Register file: R0 reads as 0; writes to 0 are ignored. The write is visible to a same-cycle read (write-through bypass).
- Hazard tracking uses a registered record of the last issued instruction: `prev_wr`, `prev_rd`, `prev_ld`.
  - `is_valN_data_hazard` = rN field used as a register source, and `prev_wr`, and rN==`prev_rd`, and `prev_rd`!=0.
  - `is_mem_data_hazard` = `prev_ld`, and either val hazard is set.
- Stall: branch or ST whose r3 matches `prev_rd` while `prev_wr`.
  - `instr_ready`=0 for one cycle; a bubble issues (all flags 0, `is_halt`=0).
  - The record clears, so the next cycle reads the written-back value.
- No valid instruction: issue a bubble and clear the record.

## Timing
- Latency 1: the instruction sampled at edge N drives outputs after edge N.
- Reset (async, immediate): all flags 0 except `is_halt`=1; vals 0; hazards 0; record cleared; `instr_ready`=1 once `rst` is high.
- `do_branch` high at an edge:
  - Outputs load a bubble and the record clears.
  - The current `instr` is consumed and discarded, so `instr_ready` stays 1.
  - `do_branch` has priority over a stall.
- `wb_en` and a read of the same register in the same cycle: the new data is registered.
- A stall lasts exactly one cycle, then the held instruction issues with hazard flags 0.

## Configuration
- `DECODE_ILLEGAL_TRAP_EN` defined: undefined opcodes (C, D, E) issue with `is_halt`=1 and all other flags 0.
- Not defined: they decode as NOP.

## Structure
- Package `isa_pkg`: `block`, `addr`, `reg_idx` typedefs; opcode constants; `DATA_W`, `NREG`.
- Sub-module `reg_file`: 16×DATA_W array, two read ports plus an r3 read port, one write port, bypass, R0 hardwired. Reset clears all entries.
- Decode, hazard and stall logic stay in `decode_stage`.

## Test plan
- Reset, then release: `is_halt`=1 and vals 0. LI r1,0x05 issues `is_add`, `val1`=5, `val3`=1, reg write.
- ADD r3,r1,r2 directly after LI r1: `is_val1_data_hazard`=1, `is_val2_data_hazard`=0, `is_mem_data_hazard`=0.
- LD r4 then SUB r5,r4,r4: both val hazards set, `is_mem_data_hazard`=1.
- `wb_en`, `wb_addr`=2, `wb_data`=0x1234 in the same cycle as decoding OR r6,r2,r0: `val1`=0x1234, `val2`=0.
- LI r7 followed by BEQ r7: `instr_ready` low for 1 cycle and one bubble. The branch then issues with `val3`=R7 after write-back. `do_branch` during the stall gives a bubble and the branch is dropped.
- Opcode 0xC: halt with the macro defined, NOP without it.
